uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter PAYLOAD_BITS, default 8, is the received character width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, is the receive FIFO depth in entries; it SHALL be a power of two, at least 2.
REQ-003 Port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port rx_valid, input, 1 bit: single-cycle pulse from the receiver; a character is complete.
REQ-006 Port rx_data, input, PAYLOAD_BITS bits: the received character, valid with rx_valid.
REQ-007 Port rx_break, input, 1 bit: BREAK indication, valid with rx_valid.
REQ-008 Port rx_en, output, 1 bit: receiver enable, driven to the receiver.
REQ-009 Port bus_req, input, 1 bit: single-cycle bus access request.
REQ-010 Port bus_we, input, 1 bit: write strobe, qualified by bus_req.
REQ-011 Port bus_addr, input, 4 bits: byte address; only bits [3:2] are decoded.
REQ-012 Port bus_wdata, input, 32 bits: write data.
REQ-013 Port bus_rdata, output, 32 bits: read data, valid with bus_ack.
REQ-014 Port bus_ack, output, 1 bit: access-complete pulse.
REQ-015 Port irq, output, 1 bit: level interrupt.

Function
REQ-016 The register map SHALL be:
- 0x0 DATA (read-only): the FIFO head, zero-extended.
- 0x4 STATUS: bit0 not_empty; bit1 full; bit2 overrun (sticky); bit3 break (sticky); bits[12:8] level.
- 0x8 CTRL (read/write): bit0 rx_enable; bit1 irq_enable; bit2 flush (write-1, self-clearing, reads 0).
- 0xC: reads 0, writes ignored.
REQ-017 bus_ack SHALL assert exactly one cycle after each bus_req cycle, for one cycle; bus_rdata SHALL be registered on that cycle and be 0 when bus_ack is low.
REQ-018 A read of DATA with the FIFO non-empty SHALL return the head and pop one entry; the pop is visible in STATUS from the bus_ack cycle onward.
REQ-019 A read of DATA with the FIFO empty SHALL return 0 and leave the pointers unchanged.
REQ-020 A write to STATUS SHALL clear overrun where bus_wdata[2]=1 and clear break where bus_wdata[3]=1 (write-1-to-clear); all other STATUS bits are read-only.
REQ-021 rx_en SHALL equal the registered CTRL.rx_enable.
REQ-022 rx_valid with rx_break=0 SHALL push rx_data when the FIFO is not full.
REQ-023 rx_valid with rx_break=0 when the FIFO is full and no pop occurs in the same cycle SHALL drop the character and set overrun; FIFO contents are unchanged.
REQ-024 rx_valid with rx_break=1 SHALL NOT push and SHALL set break.
REQ-025 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full (no overrun) and when it is empty with level 0 (the pop returns 0 and the push lands).
REQ-026 A flush write SHALL empty the FIFO in the cycle after bus_req.
REQ-027 A push coincident with the flush update cycle SHALL be discarded without setting overrun.
REQ-028 The sticky flags SHALL be unaffected by a flush.
REQ-029 If a set event and a W1C clear of the same flag occur in the same cycle, set SHALL win.
REQ-030 Level SHALL be a (log2(FIFO_DEPTH)+1)-bit occupancy count ranging 0..FIFO_DEPTH; the pointers wrap modulo FIFO_DEPTH.
REQ-031 irq SHALL be registered: irq_enable & (not_empty | overrun | break).
REQ-032 rx_valid arriving while rx_enable=0 SHALL be ignored.

Reset
REQ-033 On rst_n=0 at a rising clk edge, the FIFO SHALL be emptied, the pointers zeroed and the sticky flags cleared.
REQ-034 On reset, CTRL SHALL become 0, and rx_en, irq, bus_ack and bus_rdata SHALL be 0.
REQ-035 A reset while a bus access is pending SHALL cancel its bus_ack.
REQ-036 FIFO storage contents need not be reset.

Structure
REQ-037 The register offsets, the STATUS/CTRL bit positions and the default PAYLOAD_BITS SHALL live in a shared package, uart_pkg.
REQ-038 The FIFO SHALL be a sub-module, sync_fifo (parameters WIDTH and DEPTH), with push, pop, flush, full, empty and level.
REQ-039 The register decode, sticky flags and irq logic SHALL reside in uart_rx_ctrl.

Verification
REQ-040 CTRL=0x3, then push 0x41 and 0x42 -> irq=1 within 1 cycle; STATUS level=2; DATA reads return 0x41 then 0x42; irq drops after the second ack.
REQ-041 Push 17 characters (0x00..0x10) with depth 16 -> STATUS full=1, overrun=1; reads return 0x00..0x0F; the 0x10 character is lost.
REQ-042 With the FIFO full, rx_valid (0x55) in the same cycle as a DATA read -> the read returns the head, the level stays 16, overrun stays 0.
REQ-043 rx_valid with rx_break=1 and rx_data=0x00 -> break=1 and level unchanged; write STATUS=0x8 -> break=0.
REQ-044 Push 3 characters, write CTRL=0x5 -> level=0 next cycle, CTRL reads 0x1; a DATA read on the empty FIFO returns 0.
REQ-045 Assert reset with 4 entries held and a bus_req in flight -> no bus_ack, and all outputs 0 after reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register offsets,
// STATUS/CTRL bit positions, bus geometry and the default character width.
package uart_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 8;
  localparam int BUS_AW = 4;
  localparam int BUS_DW = 32;

  // Byte offsets of the four registers.
  localparam logic [BUS_AW-1:0] OFS_DATA   = 4'h0;
  localparam logic [BUS_AW-1:0] OFS_STATUS = 4'h4;
  localparam logic [BUS_AW-1:0] OFS_CTRL   = 4'h8;
  localparam logic [BUS_AW-1:0] OFS_RSVD   = 4'hC;

  // Register select, taken from address bits [3:2].
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  // STATUS bit positions.
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_BREAK     = 3;
  localparam int ST_LEVEL_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_RX_ENABLE  = 0;
  localparam int CTRL_IRQ_ENABLE = 1;
  localparam int CTRL_FLUSH      = 2;

  // Width of an occupancy count able to hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Single-cycle request / registered-acknowledge register bus of the
// UART receive controller.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop (also when full), flush with
// priority over both, and an occupancy count covering 0..DEPTH.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
  logic [AW:0]      level_d, level_q;
  logic             do_push_s, do_pop_s;

  // Accept/reject each request and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop & ~empty & ~flush;
    do_push_s = push & (~full | do_pop_s) & ~flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == {(AW+1){1'b0}});
  assign level = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received characters in a FIFO and
// exposes DATA/STATUS/CTRL registers, sticky overrun/break flags and a
// level interrupt on a simple request/acknowledge bus.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    rx_break,
  output logic                    rx_en,
  uart_rx_ctrl_if.slave           bus,
  output logic                    irq
);

  localparam int LW = level_width(FIFO_DEPTH);

  reg_sel_e                reg_sel_s;
  logic                    rd_s, wr_s, ctrl_wr_s;
  logic                    pop_s, push_s, flush_s;
  logic                    ovr_evt_s, brk_evt_s, ovr_clr_s, brk_clr_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [PAYLOAD_BITS-1:0] fifo_head_s;
  logic [LW-1:0]           fifo_level_s;
  logic [BUS_DW-1:0]       status_s;
  logic [BUS_DW-1:0]       rdata_d, rdata_q;
  logic                    rx_en_d, rx_en_q;
  logic                    irq_en_d, irq_en_q;
  logic                    ovr_d, ovr_q;
  logic                    brk_d, brk_q;
  logic                    ack_d, ack_q;
  logic                    irq_d, irq_q;
  logic                    unused_s;

  // Address bits [1:0] and the upper write-data bits carry no meaning here.
  assign unused_s = ^{bus.bus_addr[1:0], bus.bus_wdata[BUS_DW-1:4]};

  sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata (rx_data),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Decode the bus access and the receiver events for this cycle.
  always_comb begin
    reg_sel_s = reg_sel_e'(bus.bus_addr[3:2]);
    rd_s      = bus.bus_req & ~bus.bus_we;
    wr_s      = bus.bus_req & bus.bus_we;
    ctrl_wr_s = wr_s & (reg_sel_s == REG_CTRL);
    pop_s     = rd_s & (reg_sel_s == REG_DATA);
    flush_s   = ctrl_wr_s & bus.bus_wdata[CTRL_FLUSH];
    ovr_clr_s = wr_s & (reg_sel_s == REG_STATUS) & bus.bus_wdata[ST_OVERRUN];
    brk_clr_s = wr_s & (reg_sel_s == REG_STATUS) & bus.bus_wdata[ST_BREAK];
    push_s    = rx_valid & ~rx_break & rx_en_q;
    brk_evt_s = rx_valid & rx_break & rx_en_q;
    // A full FIFO still takes the character if a pop frees a slot this cycle;
    // a character arriving with a flush is discarded silently.
    ovr_evt_s = push_s & fifo_full_s & ~pop_s & ~flush_s;
  end

  // Next state of CTRL, sticky flags (set beats clear), ack and irq.
  always_comb begin
    if (ctrl_wr_s) begin
      rx_en_d  = bus.bus_wdata[CTRL_RX_ENABLE];
      irq_en_d = bus.bus_wdata[CTRL_IRQ_ENABLE];
    end else begin
      rx_en_d  = rx_en_q;
      irq_en_d = irq_en_q;
    end
    if (ovr_evt_s)      ovr_d = 1'b1;
    else if (ovr_clr_s) ovr_d = 1'b0;
    else                ovr_d = ovr_q;
    if (brk_evt_s)      brk_d = 1'b1;
    else if (brk_clr_s) brk_d = 1'b0;
    else                brk_d = brk_q;
    ack_d = bus.bus_req;
    irq_d = irq_en_q & (~fifo_empty_s | ovr_q | brk_q);
  end

  // Assemble STATUS and select the read data returned with the ack.
  always_comb begin
    status_s                         = {BUS_DW{1'b0}};
    status_s[ST_NOT_EMPTY]           = ~fifo_empty_s;
    status_s[ST_FULL]                = fifo_full_s;
    status_s[ST_OVERRUN]             = ovr_q;
    status_s[ST_BREAK]               = brk_q;
    status_s[ST_LEVEL_LSB +: LW]     = fifo_level_s;
    rdata_d                          = {BUS_DW{1'b0}};
    if (rd_s) begin
      case (reg_sel_s)
        REG_DATA: begin
          if (!fifo_empty_s) rdata_d = BUS_DW'(fifo_head_s);
          else               rdata_d = {BUS_DW{1'b0}};
        end
        REG_STATUS: rdata_d = status_s;
        REG_CTRL: begin
          rdata_d                  = {BUS_DW{1'b0}};
          rdata_d[CTRL_RX_ENABLE]  = rx_en_q;
          rdata_d[CTRL_IRQ_ENABLE] = irq_en_q;
        end
        REG_RSVD: rdata_d = {BUS_DW{1'b0}};
        default:  rdata_d = {BUS_DW{1'b0}};
      endcase
    end else begin
      rdata_d = {BUS_DW{1'b0}};
    end
  end

  // Control, flag and output registers; reset also cancels a pending ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= {BUS_DW{1'b0}};
      irq_q    <= 1'b0;
    end else begin
      rx_en_q  <= rx_en_d;
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      brk_q    <= brk_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign rx_en         = rx_en_q;
  assign irq           = irq_q;
  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a table of directed vectors, hand-written corner
// sequences and a random run, all checked against a queue-based model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       rx_en;
  logic       irq;

  uart_rx_ctrl_if bus_if();

  uart_rx_ctrl #(.PAYLOAD_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_break (rx_break),
    .rx_en    (rx_en),
    .bus      (bus_if),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  bit m_ovr, m_brk, m_rxen, m_irqen, m_irq;

  typedef struct {
    string       name;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rxb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = 32'd0;
    s[12:8] = 5'(m_q.size());
    s[3]    = m_brk;
    s[2]    = m_ovr;
    s[1]    = (m_q.size() == DEPTH);
    s[0]    = (m_q.size() != 0);
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovr = 0; m_brk = 0; m_rxen = 0; m_irqen = 0; m_irq = 0;
  endtask

  // One clock of the register-map rules; returns the data the ack carries.
  task automatic model(input logic req, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                       input logic rxb, output logic [31:0] rd);
    bit flush;
    bit pre_rxen;
    flush    = 0;
    pre_rxen = m_rxen;
    m_irq    = m_irqen & ((m_q.size() != 0) | m_ovr | m_brk);
    rd       = 32'd0;
    if (req && !we) begin
      case (addr[3:2])
        2'd0: if (m_q.size() > 0) rd = {24'd0, m_q.pop_front()};
        2'd1: rd = m_status();
        2'd2: rd = {30'd0, m_irqen, m_rxen};
        default: rd = 32'd0;
      endcase
    end
    if (req && we) begin
      case (addr[3:2])
        2'd1: begin
          if (wdata[2]) m_ovr = 0;
          if (wdata[3]) m_brk = 0;
        end
        2'd2: begin
          m_rxen  = wdata[0];
          m_irqen = wdata[1];
          if (wdata[2]) begin flush = 1; m_q.delete(); end
        end
        default: ;
      endcase
    end
    if (rxv && pre_rxen) begin
      if (rxb) m_brk = 1;
      else if (!flush) begin
        if (m_q.size() < DEPTH) m_q.push_back(rxd);
        else m_ovr = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = 4'h0; bus_if.bus_wdata = 32'h0;
    rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
  endtask

  // Drive one cycle, step the model, check ack/irq/rx_en after the edge.
  task automatic step(input string tag, input logic req, input logic we, input logic [3:0] addr,
                      input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                      input logic rxb, output logic [31:0] mdl_rd, output logic [31:0] dut_rd);
    bus_if.bus_req = req; bus_if.bus_we = we;
    bus_if.bus_addr = addr; bus_if.bus_wdata = wdata;
    rx_valid = rxv; rx_data = rxd; rx_break = rxb;
    model(req, we, addr, wdata, rxv, rxd, rxb, mdl_rd);
    @(posedge clk); #1;
    dut_rd = bus_if.bus_rdata;
    check({tag, " ack"}, 32'(bus_if.bus_ack), 32'(req));
    check({tag, " irq"}, 32'(irq), 32'(m_irq));
    check({tag, " rx_en"}, 32'(rx_en), 32'(m_rxen));
    idle_inputs();
  endtask

  task automatic rd(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] m, d;
    step(name, 1'b1, 1'b0, addr, 32'h0, 1'b0, 8'h00, 1'b0, m, d);
    check(name, d, exp);
  endtask

  task automatic wr(input string name, input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] m, d;
    step(name, 1'b1, 1'b1, addr, data, 1'b0, 8'h00, 1'b0, m, d);
  endtask

  task automatic rx(input string name, input logic [7:0] data, input logic brk);
    logic [31:0] m, d;
    step(name, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, data, brk, m, d);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] m, d;

    tbl[0]  = '{"t wr ctrl",      1'b1, 1'b1, OFS_CTRL,   32'h1, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[1]  = '{"t push 41",      1'b0, 1'b0, OFS_DATA,   32'h0, 1'b1, 8'h41, 1'b0, 32'h0};
    tbl[2]  = '{"t push 42",      1'b0, 1'b0, OFS_DATA,   32'h0, 1'b1, 8'h42, 1'b0, 32'h0};
    tbl[3]  = '{"t status lvl2",  1'b1, 1'b0, OFS_STATUS, 32'h0, 1'b0, 8'h00, 1'b0, 32'h201};
    tbl[4]  = '{"t data 41",      1'b1, 1'b0, OFS_DATA,   32'h0, 1'b0, 8'h00, 1'b0, 32'h41};
    tbl[5]  = '{"t status alias", 1'b1, 1'b0, 4'h7,       32'h0, 1'b0, 8'h00, 1'b0, 32'h101};
    tbl[6]  = '{"t data 42",      1'b1, 1'b0, OFS_DATA,   32'h0, 1'b0, 8'h00, 1'b0, 32'h42};
    tbl[7]  = '{"t data empty",   1'b1, 1'b0, OFS_DATA,   32'h0, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[8]  = '{"t break",        1'b0, 1'b0, OFS_DATA,   32'h0, 1'b1, 8'h00, 1'b1, 32'h0};
    tbl[9]  = '{"t status brk",   1'b1, 1'b0, OFS_STATUS, 32'h0, 1'b0, 8'h00, 1'b0, 32'h8};
    tbl[10] = '{"t w1c brk",      1'b1, 1'b1, OFS_STATUS, 32'h8, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[11] = '{"t status clr",   1'b1, 1'b0, OFS_STATUS, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[12] = '{"t ctrl rd",      1'b1, 1'b0, OFS_CTRL,   32'h0, 1'b0, 8'h00, 1'b0, 32'h1};
    tbl[13] = '{"t rsvd rd",      1'b1, 1'b0, OFS_RSVD,   32'h0, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[14] = '{"t ctrl off",     1'b1, 1'b1, OFS_CTRL,   32'h0, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[15] = '{"t push disabled",1'b0, 1'b0, OFS_DATA,   32'h0, 1'b1, 8'h99, 1'b0, 32'h0};
    tbl[16] = '{"t status still0",1'b1, 1'b0, OFS_STATUS, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[17] = '{"t ctrl rd0",     1'b1, 1'b0, OFS_CTRL,   32'h0, 1'b0, 8'h00, 1'b0, 32'h0};

    idle_inputs();
    do_reset();
    check("reset rx_en", 32'(rx_en), 32'h0);
    check("reset irq",   32'(irq),   32'h0);
    check("reset ack",   32'(bus_if.bus_ack), 32'h0);
    check("reset rdata", bus_if.bus_rdata, 32'h0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].name, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata,
           tbl[i].rxv, tbl[i].rxd, tbl[i].rxb, m, d);
      check(tbl[i].name, d, tbl[i].exp);
    end

    // Interrupt follows data and clears once drained.
    do_reset();
    wr("irq ctrl", OFS_CTRL, 32'h3);
    rx("irq push41", 8'h41, 1'b0);
    rx("irq push42", 8'h42, 1'b0);
    check("irq raised", 32'(irq), 32'h1);
    rd("irq status", OFS_STATUS, 32'h201);
    rd("irq data41", OFS_DATA, 32'h41);
    rd("irq data42", OFS_DATA, 32'h42);
    step("irq idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, m, d);
    check("irq dropped", 32'(irq), 32'h0);

    // Overfill by one: last character lost, overrun set.
    do_reset();
    wr("ovf ctrl", OFS_CTRL, 32'h1);
    for (int i = 0; i <= 16; i++) rx("ovf push", 8'(i), 1'b0);
    rd("ovf status", OFS_STATUS, 32'h1007);
    for (int i = 0; i < 16; i++) rd("ovf data", OFS_DATA, 32'(i));
    rd("ovf lost", OFS_DATA, 32'h0);
    rd("ovf sticky", OFS_STATUS, 32'h4);

    // Push and pop together on a full FIFO; set beats W1C clear.
    wr("full w1c", OFS_STATUS, 32'h4);
    for (int i = 0; i < 16; i++) rx("full fill", 8'(8'h20 + i), 1'b0);
    step("full rdpush", 1'b1, 1'b0, OFS_DATA, 32'h0, 1'b1, 8'h55, 1'b0, m, d);
    check("full rdpush data", d, 32'h20);
    rd("full status", OFS_STATUS, 32'h1003);
    step("setwins", 1'b1, 1'b1, OFS_STATUS, 32'h4, 1'b1, 8'h66, 1'b0, m, d);
    rd("setwins status", OFS_STATUS, 32'h1007);
    for (int i = 1; i < 16; i++) rd("full drain", OFS_DATA, 32'(8'h20 + i));
    rd("full tail55", OFS_DATA, 32'h55);

    // Break does not push; W1C clears it.
    do_reset();
    wr("brk ctrl", OFS_CTRL, 32'h1);
    rx("brk push11", 8'h11, 1'b0);
    rx("brk event", 8'h00, 1'b1);
    rd("brk status", OFS_STATUS, 32'h109);
    wr("brk w1c", OFS_STATUS, 32'h8);
    rd("brk cleared", OFS_STATUS, 32'h101);

    // Flush with a coincident push; empty push+pop.
    rx("fl push12", 8'h12, 1'b0);
    rx("fl push13", 8'h13, 1'b0);
    step("fl flush", 1'b1, 1'b1, OFS_CTRL, 32'h5, 1'b1, 8'h77, 1'b0, m, d);
    rd("fl status", OFS_STATUS, 32'h0);
    rd("fl ctrl", OFS_CTRL, 32'h1);
    rd("fl data empty", OFS_DATA, 32'h0);
    step("emp rdpush", 1'b1, 1'b0, OFS_DATA, 32'h0, 1'b1, 8'h88, 1'b0, m, d);
    check("emp rdpush data", d, 32'h0);
    rd("emp status", OFS_STATUS, 32'h101);
    rd("emp data88", OFS_DATA, 32'h88);

    // Reset with data held and a request in flight.
    do_reset();
    wr("rst ctrl", OFS_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) rx("rst push", 8'(8'hA0 + i), 1'b0);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = OFS_DATA;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst ack cancel", 32'(bus_if.bus_ack), 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("rst rx_en", 32'(rx_en), 32'h0);
    check("rst irq",   32'(irq),   32'h0);
    check("rst rdata", bus_if.bus_rdata, 32'h0);
    rd("rst status", OFS_STATUS, 32'h0);

    // Random traffic against the model.
    wr("rand ctrl", OFS_CTRL, 32'h3);
    for (int n = 0; n < 3000; n++) begin
      logic        req, we, rxv, rxb;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  rxd;
      req   = ($urandom_range(0, 99) < 45);
      we    = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if (we && addr[3:2] == 2'd2) begin
        wdata[0] = ($urandom_range(0, 9) != 0);
        wdata[2] = ($urandom_range(0, 15) == 0);
      end
      rxv = ($urandom_range(0, 99) < 55);
      rxd = 8'($urandom);
      rxb = ($urandom_range(0, 19) == 0);
      step("rand", req, we, addr, wdata, rxv, rxd, rxb, m, d);
      check("rand rdata", d, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
